// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the two-requester Wishbone arbiter.
package wb_arbiter_pkg;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 32'd255;
   localparam int unsigned WB_AW = 32'd32;
   localparam int unsigned WB_DW = 32'd32;
   localparam int unsigned WB_SW = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   typedef logic owner_t;

   localparam owner_t OWNER_M0 = 1'b0;
   localparam owner_t OWNER_M1 = 1'b1;

endpackage

// File: rtl/wb_bus.sv
// Classic Wishbone bus bundle; master drives the request, slave drives the response.
interface wb_bus;
   import wb_arbiter_pkg::*;

   logic             cyc;
   logic             stb;
   logic             we;
   logic [WB_AW-1:0] addr;
   logic [WB_DW-1:0] wdata;
   logic [WB_SW-1:0] sel;
   logic             ack;
   logic             err;
   logic [WB_DW-1:0] rdata;

   modport master (output cyc, stb, we, addr, wdata, sel, input ack, err, rdata);
   modport slave  (input cyc, stb, we, addr, wdata, sel, output ack, err, rdata);

endinterface

// File: rtl/wb_arbiter_timeout.sv
// Stall watchdog: counts consecutive stalled cycles of the current owner and
// flags expiry combinationally in the cycle the limit is reached.
module wb_arbiter_timeout
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic active,
   input  logic done,
   output logic expired
);

   localparam logic [15:0] LIMIT_M1 = 16'(TIMEOUT_CYCLES - 32'd1);

   logic [15:0] count_q;
   logic [15:0] count_d;

   // Expiry depends only on the count, never on the slave response, so no
   // combinational path runs from ack back into the arbiter's bus outputs.
   assign expired = active & (count_q == LIMIT_M1);

   // Stall counter next state
   always_comb begin
      count_d = count_q;
      if (!active || done || expired) begin
         count_d = 16'd0;
      end else begin
         count_d = count_q + 16'd1;
      end
   end

   // Stall counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= 16'd0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/wb_arbiter2.sv
// Round-robin, bus-locking arbiter for two Wishbone masters sharing one slave.
// Define WB_ARBITER_TIMEOUT_EN to add the stall watchdog (wb_arbiter_timeout).
module wb_arbiter2
   import wb_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
   input  logic  clk,
   input  logic  reset_n,
   wb_bus.slave  m0_bus,
   wb_bus.slave  m1_bus,
   wb_bus.master bus_master
);

   state_t state_q;
   state_t state_d;
   owner_t last_owner_q;
   owner_t last_owner_d;
   logic   req0_s;
   logic   req1_s;
   logic   expired_s;

   assign req0_s = m0_bus.cyc & m0_bus.stb;
   assign req1_s = m1_bus.cyc & m1_bus.stb;

`ifdef WB_ARBITER_TIMEOUT_EN
   logic own_stb_s;
   logic done_s;

   assign own_stb_s = ((state_q == OWN0) & m0_bus.stb) | ((state_q == OWN1) & m1_bus.stb);
   assign done_s    = bus_master.ack | bus_master.err;

   wb_arbiter_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .active  (own_stb_s),
      .done    (done_s),
      .expired (expired_s)
   );
`else
   logic unused_timeout_s;

   assign unused_timeout_s = ^TIMEOUT_CYCLES;
   assign expired_s        = 1'b0;
`endif

   // Arbitration FSM next state; ownership is only released through IDLE
   always_comb begin
      state_d      = state_q;
      last_owner_d = last_owner_q;
      case (state_q)
         IDLE: begin
            if (req0_s && req1_s) begin
               state_d = (last_owner_q == OWNER_M1) ? OWN0 : OWN1;
            end else if (req0_s) begin
               state_d = OWN0;
            end else if (req1_s) begin
               state_d = OWN1;
            end else begin
               state_d = IDLE;
            end
         end
         OWN0: begin
            if (!m0_bus.cyc) begin
               state_d      = IDLE;
               last_owner_d = OWNER_M0;
            end else begin
               state_d = OWN0;
            end
         end
         OWN1: begin
            if (!m1_bus.cyc) begin
               state_d      = IDLE;
               last_owner_d = OWNER_M1;
            end else begin
               state_d = OWN1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // FSM and round-robin state registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_owner_q <= OWNER_M1;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
      end
   end

   // Combinational request/response steering; a watchdog expiry masks the
   // downstream strobe and turns the owner's response into an error
   always_comb begin
      bus_master.cyc   = 1'b0;
      bus_master.stb   = 1'b0;
      bus_master.we    = 1'b0;
      bus_master.addr  = '0;
      bus_master.wdata = '0;
      bus_master.sel   = '0;
      m0_bus.ack       = 1'b0;
      m0_bus.err       = 1'b0;
      m0_bus.rdata     = bus_master.rdata;
      m1_bus.ack       = 1'b0;
      m1_bus.err       = 1'b0;
      m1_bus.rdata     = bus_master.rdata;
      case (state_q)
         OWN0: begin
            bus_master.cyc   = m0_bus.cyc & ~expired_s;
            bus_master.stb   = m0_bus.stb & ~expired_s;
            bus_master.we    = m0_bus.we;
            bus_master.addr  = m0_bus.addr;
            bus_master.wdata = m0_bus.wdata;
            bus_master.sel   = m0_bus.sel;
            m0_bus.ack       = bus_master.ack & ~expired_s;
            m0_bus.err       = bus_master.err | expired_s;
         end
         OWN1: begin
            bus_master.cyc   = m1_bus.cyc & ~expired_s;
            bus_master.stb   = m1_bus.stb & ~expired_s;
            bus_master.we    = m1_bus.we;
            bus_master.addr  = m1_bus.addr;
            bus_master.wdata = m1_bus.wdata;
            bus_master.sel   = m1_bus.sel;
            m1_bus.ack       = bus_master.ack & ~expired_s;
            m1_bus.err       = bus_master.err | expired_s;
         end
         default: begin
            bus_master.cyc = 1'b0;
         end
      endcase
   end

endmodule
